// File: rtl/fetch_sequencer.sv
// Program-counter owner and instruction-fetch sequencer: one outstanding imem request,
// redirect absorption with stale-fetch discard, single-entry valid/ready hand-off to decode.
module fetch_sequencer #(
  parameter int                      AddressWidth = 10,
  parameter int                      DataWidth    = 32,
  parameter logic [AddressWidth-1:0] ResetPc      = '0,
  parameter int                      PcStep       = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    redirect_i,
  input  logic [AddressWidth-1:0] redirect_target_i,
  output logic                    imem_req_o,
  output logic [AddressWidth-1:0] imem_addr_o,
  input  logic                    imem_gnt_i,
  input  logic                    imem_rvalid_i,
  input  logic [DataWidth-1:0]    imem_rdata_i,
  output logic                    instr_valid_o,
  output logic [DataWidth-1:0]    instr_o,
  output logic [AddressWidth-1:0] instr_pc_o,
  input  logic                    instr_ready_i,
  output logic [AddressWidth-1:0] pc_o
);

  typedef enum logic [2:0] {BOOT, ISSUE, WAIT, DROP, HOLD} state_e;

  state_e                  state_q, state_d;
  logic [AddressWidth-1:0] pc_q, pc_d;
  logic [DataWidth-1:0]    instr_q, instr_d;
  logic [AddressWidth-1:0] ipc_q, ipc_d;
  logic                    req_q, valid_q;
  logic [AddressWidth-1:0] addr_q;

  // Redirect targets are always word aligned.
  function automatic logic [AddressWidth-1:0] align_target(input logic [AddressWidth-1:0] t);
    return t & ~AddressWidth'(3);
  endfunction

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    case (state_q)
      BOOT: state_d = ISSUE;
      ISSUE: begin
        if (redirect_i) pc_d = align_target(redirect_target_i);
        // A grant coinciding with a redirect fetches the old PC; its data must be thrown away.
        if (imem_gnt_i) state_d = redirect_i ? DROP : WAIT;
      end
      WAIT: begin
        if (redirect_i) begin
          pc_d    = align_target(redirect_target_i);
          state_d = imem_rvalid_i ? ISSUE : DROP;
        end else if (imem_rvalid_i) begin
          instr_d = imem_rdata_i;
          ipc_d   = pc_q;
          pc_d    = pc_q + AddressWidth'(PcStep);
          state_d = HOLD;
        end
      end
      DROP: begin
        if (redirect_i)    pc_d    = align_target(redirect_target_i);
        if (imem_rvalid_i) state_d = ISSUE;
      end
      HOLD: begin
        // Redirect wins over a same-cycle handshake: the held instruction is on the wrong path.
        if (redirect_i) begin
          pc_d    = align_target(redirect_target_i);
          state_d = ISSUE;
        end else if (instr_ready_i) begin
          state_d = ISSUE;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= BOOT;
      pc_q    <= ResetPc;
      instr_q <= '0;
      ipc_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      req_q   <= (state_d == ISSUE);
      addr_q  <= (state_d == ISSUE) ? pc_d : '0;
      valid_q <= (state_d == HOLD);
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = addr_q;
  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = ipc_q;
  assign pc_o          = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: behavioural imem with programmable grant/read latency,
// scoreboard of expected {pc, data} popped on each decode handshake.
module tb_fetch_sequencer;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          redirect_i;
  logic [AW-1:0] redirect_target_i;
  logic          imem_req_o;
  logic [AW-1:0] imem_addr_o;
  logic          imem_gnt_i;
  logic          imem_rvalid_i;
  logic [DW-1:0] imem_rdata_i;
  logic          instr_valid_o;
  logic [DW-1:0] instr_o;
  logic [AW-1:0] instr_pc_o;
  logic          instr_ready_i;
  logic [AW-1:0] pc_o;

  fetch_sequencer #(.AddressWidth(AW), .DataWidth(DW), .ResetPc(10'h000), .PcStep(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .redirect_i(redirect_i), .redirect_target_i(redirect_target_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .instr_valid_o(instr_valid_o),
    .instr_o(instr_o), .instr_pc_o(instr_pc_o), .instr_ready_i(instr_ready_i), .pc_o(pc_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] pc; logic [DW-1:0] data; } exp_t;
  typedef struct { int gnt_lat; int rv_lat; int exp_lat; } vec_t;

  exp_t          sb[$];
  logic [AW-1:0] gnt_log[$];
  int            checks = 0, failures = 0, cyc = 0;
  int            gnt_lat = 0, rv_lat = 1, req_age = 0, pend_cnt = 0;
  bit            pend = 0;
  logic [AW-1:0] pend_addr = '0;

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    return 32'hC0DE_0000 | {22'd0, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  task automatic push_exp(input logic [AW-1:0] pc);
    exp_t e;
    e.pc   = pc;
    e.data = mem_data(pc);
    sb.push_back(e);
  endtask

  // Memory model: inputs for the coming rising edge are decided at the falling edge.
  task automatic drive_mem();
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    if (!rst_ni) begin
      pend    = 0;
      req_age = 0;
      return;
    end
    if (pend) begin
      if (pend_cnt <= 1) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_data(pend_addr);
        pend          = 0;
      end else pend_cnt--;
    end
    if (imem_req_o) begin
      if (req_age >= gnt_lat) begin
        imem_gnt_i = 1'b1;
        pend       = 1;
        pend_cnt   = rv_lat;
        pend_addr  = imem_addr_o;
        req_age    = 0;
        gnt_log.push_back(imem_addr_o);
      end else req_age++;
    end
  endtask

  task automatic next();
    exp_t e;
    if (instr_valid_o && instr_ready_i && !redirect_i) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_instr actual=pc %0h expected=no handshake", instr_pc_o);
      end else begin
        e = sb.pop_front();
        chk("instr_pc", 32'(instr_pc_o), 32'(e.pc));
        chk("instr_data", instr_o, e.data);
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    drive_mem();
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!instr_valid_o && n < 40) begin next(); n++; end
    if (!instr_valid_o) fail_now(name);
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!imem_req_o && n < 40) begin next(); n++; end
    if (!imem_req_o) fail_now(name);
  endtask

  task automatic run_until_empty(input string name);
    int n = 0;
    while (sb.size() > 0 && n < 80) begin next(); n++; end
    if (sb.size() > 0) begin
      fail_now(name);
      sb.delete();
    end
  endtask

  vec_t vecs[4];

  initial begin
    int n, c0;
    vecs[0] = '{0, 1, 2};
    vecs[1] = '{2, 1, 4};
    vecs[2] = '{0, 3, 4};
    vecs[3] = '{3, 2, 6};

    rst_ni = 1'b0; redirect_i = 1'b0; redirect_target_i = '0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0; instr_ready_i = 1'b0;
    @(negedge clk);
    chk("rst_req", 32'(imem_req_o), 0);
    chk("rst_addr", 32'(imem_addr_o), 0);
    chk("rst_valid", 32'(instr_valid_o), 0);
    chk("rst_instr", instr_o, 0);
    chk("rst_instr_pc", 32'(instr_pc_o), 0);
    chk("rst_pc", 32'(pc_o), 32'h000);

    // Zero-wait memory from reset release: 0x000, 0x004, 0x008.
    rst_ni = 1'b1; instr_ready_i = 1'b1;
    push_exp(10'h000); push_exp(10'h004); push_exp(10'h008);
    n = 0;
    while (!instr_valid_o && n < 10) begin next(); n++; end
    chk("first_valid_latency", 32'(n), 3);
    run_until_empty("seq_timeout");
    chk("gnt_addr0", 32'(gnt_log[0]), 32'h000);
    chk("gnt_addr1", 32'(gnt_log[1]), 32'h004);
    chk("gnt_addr2", 32'(gnt_log[2]), 32'h008);

    // Latency table: request-to-valid cycles = gnt_lat + rv_lat + 1.
    for (int i = 0; i < 4; i++) begin
      logic [AW-1:0] epc;
      epc = AW'(12 + 4 * i);
      wait_req("tbl_req_timeout");
      c0 = cyc;
      chk("tbl_addr", 32'(imem_addr_o), 32'(epc));
      push_exp(epc);
      wait_valid("tbl_valid_timeout");
      chk("tbl_latency", 32'(cyc - c0), 32'(vecs[i].exp_lat));
      if (i + 1 < 4) begin gnt_lat = vecs[i+1].gnt_lat; rv_lat = vecs[i+1].rv_lat; end
      next();
    end

    // Decode stall in HOLD for 5 cycles.
    instr_ready_i = 1'b0; gnt_lat = 0; rv_lat = 1;
    push_exp(10'h01C);
    wait_valid("stall_valid_timeout");
    for (int i = 0; i < 5; i++) begin
      next();
      chk("stall_valid", 32'(instr_valid_o), 1);
      chk("stall_pc", 32'(instr_pc_o), 32'h01C);
      chk("stall_data", instr_o, mem_data(10'h01C));
      chk("stall_no_req", 32'(imem_req_o), 0);
    end
    rv_lat = 3; instr_ready_i = 1'b1;
    next();
    chk("after_stall_req", 32'(imem_req_o), 1);
    chk("after_stall_addr", 32'(imem_addr_o), 32'h020);

    // Redirect to 0x102 while in WAIT; stale rvalid must be swallowed.
    next();
    chk("wait_no_req", 32'(imem_req_o), 0);
    redirect_i = 1'b1; redirect_target_i = 10'h102;
    next();
    redirect_i = 1'b0;
    chk("wait_redir_pc", 32'(pc_o), 32'h100);
    n = 0;
    while (!imem_req_o && n < 20) begin
      chk("wait_redir_no_valid", 32'(instr_valid_o), 0);
      next(); n++;
    end
    chk("wait_redir_addr", 32'(imem_addr_o), 32'h100);
    rv_lat = 1;
    push_exp(10'h100);
    run_until_empty("wait_redir_timeout");

    // Redirect to 0x040 in HOLD with ready=1: instruction at 0x104 dropped.
    wait_valid("hold_valid_timeout");
    chk("hold_pc", 32'(instr_pc_o), 32'h104);
    redirect_i = 1'b1; redirect_target_i = 10'h040;
    next();
    redirect_i = 1'b0;
    chk("hold_redir_valid", 32'(instr_valid_o), 0);
    chk("hold_redir_req", 32'(imem_req_o), 1);
    chk("hold_redir_addr", 32'(imem_addr_o), 32'h040);
    rv_lat = 6;
    push_exp(10'h040);
    run_until_empty("hold_redir_timeout");

    // Two redirects while a stale read is pending: last target wins.
    next();
    redirect_i = 1'b1; redirect_target_i = 10'h080;
    next();
    redirect_target_i = 10'h0C0;
    next();
    redirect_i = 1'b0;
    chk("drop_pc", 32'(pc_o), 32'h0C0);
    rv_lat = 1;
    n = 0;
    while (!imem_req_o && n < 20) begin
      chk("drop_no_valid", 32'(instr_valid_o), 0);
      next(); n++;
    end
    chk("drop_addr", 32'(imem_addr_o), 32'h0C0);
    push_exp(10'h0C0);
    gnt_lat = 3;
    run_until_empty("drop_timeout");

    // Ungranted request redirected; low target bits masked.
    redirect_i = 1'b1; redirect_target_i = 10'h203;
    next();
    redirect_i = 1'b0;
    chk("issue_redir_req", 32'(imem_req_o), 1);
    chk("issue_redir_addr", 32'(imem_addr_o), 32'h200);
    push_exp(10'h200);
    gnt_lat = 0;
    run_until_empty("issue_redir_timeout");

    // PC wrap 0x3FC -> 0x000.
    wait_valid("wrap_valid_timeout");
    redirect_i = 1'b1; redirect_target_i = 10'h3FC;
    next();
    redirect_i = 1'b0;
    push_exp(10'h3FC); push_exp(10'h000);
    rv_lat = 4;
    run_until_empty("wrap_timeout");
    chk("wrap_pc", 32'(pc_o), 32'h004);
    chk("wrap_gnt_prev", 32'(gnt_log[gnt_log.size()-2]), 32'h000);
    chk("wrap_gnt_last", 32'(gnt_log[gnt_log.size()-1]), 32'h004);

    // Asynchronous reset during WAIT.
    next();
    chk("pre_rst_wait_req", 32'(imem_req_o), 0);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_req", 32'(imem_req_o), 0);
    chk("mid_rst_valid", 32'(instr_valid_o), 0);
    chk("mid_rst_pc", 32'(pc_o), 32'h000);
    chk("mid_rst_instr", instr_o, 0);
    chk("mid_rst_instr_pc", 32'(instr_pc_o), 0);
    sb.delete();
    next(); next();
    rst_ni = 1'b1; rv_lat = 1;
    wait_req("post_rst_req_timeout");
    chk("post_rst_addr", 32'(imem_addr_o), 32'h000);
    push_exp(10'h000);
    run_until_empty("post_rst_timeout");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
